// File: rtl/bw_io_ddr_pkg.sv
//------------------------------------------------------------------------------
// Module   : bw_io_ddr_pkg
// Brief    : Shared constants for the DDR vdd_com supply monitor: FSM state
//            encodings and default qualification / drop-out cycle counts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bw_io_ddr_pkg;

    // Monitor FSM encodings, also presented externally on mon_state
    localparam logic [1:0] c_st_off  = 2'd0;
    localparam logic [1:0] c_st_qual = 2'd1;
    localparam logic [1:0] c_st_req  = 2'd2;
    localparam logic [1:0] c_st_good = 2'd3;

    // Default consecutive-high cycles to qualify power
    localparam int c_deb_cyc_dflt  = 16;
    // Default consecutive-low cycles in GOOD that declare power fail
    localparam int c_drop_cyc_dflt = 4;

endpackage : bw_io_ddr_pkg

`default_nettype wire

// File: rtl/bw_io_ddr_sync_ff.sv
//------------------------------------------------------------------------------
// Module   : bw_io_ddr_sync_ff
// Brief    : Multi-flop synchroniser bringing an asynchronous level into the
//            clk domain. Flops clear to 0 on reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bw_io_ddr_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : bw_io_ddr_sync_ff

`default_nettype wire

// File: rtl/bw_io_ddr_vddcom_mon.sv
//------------------------------------------------------------------------------
// Module   : bw_io_ddr_vddcom_mon
// Brief    : Receive-end qualifier for the DDR vdd_com supply-status line.
//            Synchronises and debounces vdd_com, runs a four-phase req/ack
//            handshake for pad-driver enable, and reports power-good,
//            power-fail pulses and a saturating glitch count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bw_io_ddr_vddcom_mon
    import bw_io_ddr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = c_deb_cyc_dflt,
    parameter int DROP_CYC    = c_drop_cyc_dflt,
    parameter int CNT_W       = 5,
    parameter int GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vdd_com,
    input  logic                pad_en_ack,
    input  logic                clr_glitch,
    output logic                pad_en_req,
    output logic                pwr_ok,
    output logic                pwr_fail,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic [1:0]          mon_state
);

    // Terminal counts: QUAL exits on its DEB_CYC-th high cycle, GOOD drops
    // on its DROP_CYC-th consecutive low cycle.
    localparam logic [CNT_W-1:0]    c_deb_last  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0]    c_drop_last = CNT_W'(DROP_CYC - 1);
    localparam logic [GLITCH_W-1:0] c_glitch_max = {GLITCH_W{1'b1}};

    logic                w_vdd_s;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_glitch_inc;
    logic                w_fail;
    logic                w_req_nxt;
    logic                w_ok_nxt;
    logic [GLITCH_W-1:0] w_glitch_nxt;
    logic                r_pad_en_req;
    logic                r_pwr_ok;
    logic                r_pwr_fail;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    bw_io_ddr_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (vdd_com),
        .q   (w_vdd_s)
    );

    // State and debounce/drop counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_off;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and event decode from the synchronised supply level
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_glitch_inc = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            c_st_off: begin
                w_cnt_nxt = '0;
                // A stale ack from a previous session blocks requalification
                if (w_vdd_s && !pad_en_ack) begin
                    w_state_nxt = c_st_qual;
                end
            end
            c_st_qual: begin
                if (!w_vdd_s) begin
                    w_state_nxt  = c_st_off;
                    w_cnt_nxt    = '0;
                    w_glitch_inc = 1'b1;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = c_st_req;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_req: begin
                w_cnt_nxt = '0;
                // Supply loss outranks a coincident ack
                if (!w_vdd_s) begin
                    w_state_nxt  = c_st_off;
                    w_fail       = 1'b1;
                    w_glitch_inc = 1'b1;
                end else if (pad_en_ack) begin
                    w_state_nxt = c_st_good;
                end
            end
            c_st_good: begin
                // Ack dropping here is a protocol error and deliberately ignored
                if (!w_vdd_s) begin
                    if (r_cnt == c_drop_last) begin
                        w_state_nxt = c_st_off;
                        w_cnt_nxt   = '0;
                        w_fail      = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (r_cnt != '0) begin
                    w_cnt_nxt    = '0;
                    w_glitch_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_off;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from next state so registered outputs align with state
    always_comb begin
        w_req_nxt = (w_state_nxt == c_st_req) || (w_state_nxt == c_st_good);
        w_ok_nxt  = (w_state_nxt == c_st_good);
        if (clr_glitch) begin
            w_glitch_nxt = '0;
        end else if (w_glitch_inc && (r_glitch_cnt != c_glitch_max)) begin
            w_glitch_nxt = r_glitch_cnt + 1'b1;
        end else begin
            w_glitch_nxt = r_glitch_cnt;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pad_en_req <= 1'b0;
            r_pwr_ok     <= 1'b0;
            r_pwr_fail   <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_pad_en_req <= w_req_nxt;
            r_pwr_ok     <= w_ok_nxt;
            r_pwr_fail   <= w_fail;
            r_glitch_cnt <= w_glitch_nxt;
        end
    end

    assign pad_en_req = r_pad_en_req;
    assign pwr_ok     = r_pwr_ok;
    assign pwr_fail   = r_pwr_fail;
    assign glitch_cnt = r_glitch_cnt;
    assign mon_state  = r_state;

endmodule : bw_io_ddr_vddcom_mon

`default_nettype wire

// File: tb/tb_bw_io_ddr_vddcom_mon.sv
//------------------------------------------------------------------------------
// Module   : tb_bw_io_ddr_vddcom_mon
// Brief    : Directed self-checking bench for bw_io_ddr_vddcom_mon
//            (DEB_CYC=16, DROP_CYC=4, SYNC_STAGES=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bw_io_ddr_vddcom_mon;

    logic       clk;
    logic       rst;
    logic       vdd_com;
    logic       pad_en_ack;
    logic       clr_glitch;
    logic       pad_en_req;
    logic       pwr_ok;
    logic       pwr_fail;
    logic [7:0] glitch_cnt;
    logic [1:0] mon_state;

    int n_checks = 0;
    int n_fail   = 0;

    bw_io_ddr_vddcom_mon #(
        .SYNC_STAGES (2),
        .DEB_CYC     (16),
        .DROP_CYC    (4),
        .CNT_W       (5),
        .GLITCH_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vdd_com    (vdd_com),
        .pad_en_ack (pad_en_ack),
        .clr_glitch (clr_glitch),
        .pad_en_req (pad_en_req),
        .pwr_ok     (pwr_ok),
        .pwr_fail   (pwr_fail),
        .glitch_cnt (glitch_cnt),
        .mon_state  (mon_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, leaving time 1 unit past the last edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. Reset state, then qualify and handshake
        rst = 1'b1; vdd_com = 1'b1; pad_en_ack = 1'b0; clr_glitch = 1'b0;
        tick(3);
        chk("rst_req",    pad_en_req, 0);
        chk("rst_ok",     pwr_ok,     0);
        chk("rst_fail",   pwr_fail,   0);
        chk("rst_glitch", glitch_cnt, 0);
        chk("rst_state",  mon_state,  0);
        rst = 1'b0;
        tick(18);
        chk("q18_state", mon_state,  1);
        chk("q18_req",   pad_en_req, 0);
        tick(1);
        chk("q19_req",   pad_en_req, 1);
        chk("q19_state", mon_state,  2);
        chk("q19_ok",    pwr_ok,     0);
        pad_en_ack = 1'b1;
        tick(1);
        chk("ack_ok",    pwr_ok,    1);
        chk("ack_state", mon_state, 3);

        // 3a. Three low cycles in GOOD: glitch, stay GOOD
        vdd_com = 1'b0;
        tick(3);
        chk("g3_ok_mid", pwr_ok, 1);
        vdd_com = 1'b1;
        tick(4);
        chk("g3_ok",     pwr_ok,     1);
        chk("g3_state",  mon_state,  3);
        chk("g3_glitch", glitch_cnt, 1);
        chk("g3_fail",   pwr_fail,   0);

        // 3b. Four low cycles in GOOD: power fail
        vdd_com = 1'b0;
        tick(5);
        chk("g4_ok_pre",   pwr_ok,   1);
        chk("g4_fail_pre", pwr_fail, 0);
        tick(1);
        chk("g4_fail",   pwr_fail,   1);
        chk("g4_ok",     pwr_ok,     0);
        chk("g4_req",    pad_en_req, 0);
        chk("g4_state",  mon_state,  0);
        tick(1);
        chk("g4_fail_w", pwr_fail,   0);
        chk("g4_glitch", glitch_cnt, 1);

        // 2. Single-cycle dropout in QUAL at cnt=10, then full requalify
        pad_en_ack = 1'b0;
        vdd_com = 1'b1;
        tick(11);
        chk("qg_state_pre", mon_state, 1);
        vdd_com = 1'b0;
        tick(1);
        vdd_com = 1'b1;
        tick(2);
        chk("qg_state",  mon_state,  0);
        chk("qg_glitch", glitch_cnt, 2);
        chk("qg_req",    pad_en_req, 0);
        tick(1);
        chk("rq_state1", mon_state, 1);
        tick(15);
        chk("rq_state16", mon_state,  1);
        chk("rq_req16",   pad_en_req, 0);
        tick(1);
        chk("rq_req",    pad_en_req, 1);
        chk("rq_state",  mon_state,  2);

        // 4. Supply loss coincident with ack in REQ
        vdd_com = 1'b0;
        tick(2);
        pad_en_ack = 1'b1;
        tick(1);
        chk("ra_state",  mon_state,  0);
        chk("ra_fail",   pwr_fail,   1);
        chk("ra_ok",     pwr_ok,     0);
        chk("ra_glitch", glitch_cnt, 3);
        tick(1);
        chk("ra_fail_w", pwr_fail, 0);
        chk("ra_ok2",    pwr_ok,   0);

        // 5. Glitch saturation and clear-wins
        pad_en_ack = 1'b0;
        for (int g = 0; g < 252; g++) begin
            vdd_com = 1'b1;
            tick(4);
            vdd_com = 1'b0;
            tick(3);
        end
        chk("sat_255", glitch_cnt, 255);
        for (int g = 0; g < 8; g++) begin
            vdd_com = 1'b1;
            tick(4);
            vdd_com = 1'b0;
            tick(3);
        end
        chk("sat_hold",  glitch_cnt, 255);
        chk("sat_state", mon_state,  0);
        vdd_com = 1'b1;
        tick(4);
        chk("clr_pre_state", mon_state, 1);
        vdd_com = 1'b0;
        tick(2);
        clr_glitch = 1'b1;
        tick(1);
        clr_glitch = 1'b0;
        chk("clr_glitch", glitch_cnt, 0);
        chk("clr_state",  mon_state,  0);

        // 6. Asynchronous reset mid-GOOD, stale ack after release
        vdd_com = 1'b1;
        tick(19);
        chk("r6_req", mon_state, 2);
        pad_en_ack = 1'b1;
        tick(1);
        chk("r6_good", pwr_ok, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_ok",    pwr_ok,     0);
        chk("ar_req",   pad_en_req, 0);
        chk("ar_state", mon_state,  0);
        chk("ar_fail",  pwr_fail,   0);
        tick(2);
        rst = 1'b0;
        tick(25);
        chk("stale_state", mon_state,  0);
        chk("stale_req",   pad_en_req, 0);
        chk("stale_fail",  pwr_fail,   0);
        pad_en_ack = 1'b0;
        tick(1);
        chk("stale_rel", mon_state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bw_io_ddr_vddcom_mon

`default_nettype wire
